// File: rtl/button_event_decoder.sv
// Turns a debounced push-button level into press/release/click/double-click/long-press pulses.
// Optional auto-repeat while held in the long state is enabled with `define BTN_REPEAT_EN.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 38_400_000,
  parameter int DCLICK_CYCLES = 16_000_000,
  parameter int REPEAT_CYCLES = 6_400_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dclick_p,
  output logic long_p,
  output logic repeat_p,
  output logic held
);

  typedef enum logic [2:0] {
    S_LOCK  = 3'd0,
    S_IDLE  = 3'd1,
    S_DOWN1 = 3'd2,
    S_WAIT2 = 3'd3,
    S_DOWN2 = 3'd4,
    S_LONG  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LONG_M1   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_M1 = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Parameter ranges the thresholds rely on; caught at elaboration.
  if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("button_event_decoder: threshold parameter out of range");
  end

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_M1 = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic press_q, press_d, release_q, release_d, click_q, click_d;
  logic dclick_q, dclick_d, long_q, long_d, repeat_q, repeat_d, held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_LOCK: if (!btn) state_d = S_IDLE;
      S_IDLE: if (btn) begin
        state_d = S_DOWN1;
        cnt_d   = CNT_ONE;
        press_d = 1'b1;
      end
      S_DOWN1: begin
        if (!btn) begin
          state_d   = S_WAIT2;
          cnt_d     = CNT_ONE;
          release_d = 1'b1;
        end else if (cnt_q == LONG_M1) begin
          state_d = S_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT2: begin
        if (btn) begin
          state_d = S_DOWN2;
          cnt_d   = CNT_ONE;
          press_d = 1'b1;
        end else if (cnt_q == DCLICK_M1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DOWN2: begin
        // Release of the second press confirms the double click in the same cycle.
        if (!btn) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          dclick_d  = 1'b1;
        end else if (cnt_q == LONG_M1) begin
          state_d = S_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LONG: begin
        if (!btn) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
`ifdef BTN_REPEAT_EN
          if (cnt_q == REPEAT_M1) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == S_DOWN1) || (state_d == S_DOWN2) || (state_d == S_LONG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOCK;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_p   = press_q;
  assign release_p = release_q;
  assign click_p   = click_q;
  assign dclick_p  = dclick_q;
  assign long_p    = long_q;
  assign repeat_p  = repeat_q;
  assign held      = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios plus random button traffic against a
// run-length reference model. Output vector order: press,release,click,dclick,long,repeat,held.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int D = 5;
  localparam int R = 3;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic press_p, release_p, click_p, dclick_p, long_p, repeat_p, held;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];

  // Reference model: lengths of the current high run and low gap.
  bit m_locked, pending, second, is_long;
  int hi_len, lo_len;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYCLES(L), .DCLICK_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .press_p(press_p), .release_p(release_p), .click_p(click_p), .dclick_p(dclick_p),
    .long_p(long_p), .repeat_p(repeat_p), .held(held)
  );

  function automatic logic [6:0] outs();
    return {press_p, release_p, click_p, dclick_p, long_p, repeat_p, held};
  endfunction

  task automatic model_reset();
    m_locked = 1'b1; pending = 1'b0; second = 1'b0; is_long = 1'b0;
    hi_len = 0; lo_len = 0;
  endtask

  task automatic model_step(input logic b, output logic [6:0] e);
    logic p, r, c, dc, lg, rp;
    {p, r, c, dc, lg, rp} = '0;
    if (m_locked) begin
      if (!b) m_locked = 1'b0;
    end else if (b) begin
      if (hi_len == 0) begin
        p = 1'b1; second = pending; pending = 1'b0; hi_len = 1; is_long = 1'b0;
      end else begin
        hi_len++;
        if (hi_len == L) begin
          lg = 1'b1; is_long = 1'b1;
        end
`ifdef BTN_REPEAT_EN
        else if (hi_len > L && (hi_len - L) % R == 0) rp = 1'b1;
`endif
      end
    end else begin
      if (hi_len > 0) begin
        r = 1'b1;
        if (!is_long) begin
          if (second) dc = 1'b1;
          else begin
            pending = 1'b1; lo_len = 1;
          end
        end
        hi_len = 0; is_long = 1'b0; second = 1'b0;
      end else if (pending) begin
        lo_len++;
        if (lo_len == D) begin
          c = 1'b1; pending = 1'b0;
        end
      end
    end
    e = {p, r, c, dc, lg, rp, (!m_locked && hi_len > 0)};
  endtask

  // Drive one sample on the falling edge, then predict the registered outputs.
  task automatic drive(input logic b);
    logic [6:0] e;
    @(negedge clk);
    btn = b;
    @(posedge clk);
    #1;
    model_step(b, e);
    exp_q.push_back(e);
  endtask

  task automatic apply_reset(input logic b);
    @(negedge clk);
    btn = b;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void add_run(inout logic pat[$], input logic lvl, input int n);
    for (int i = 0; i < n; i++) pat.push_back(lvl);
  endfunction

  task automatic test_reset();
    logic [6:0] e;
    logic pat[$];
    int presses;
    apply_reset(1'b1);
    n_checks++;
    if (outs() !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_values: got %b, expected 0000000", outs());
    end
    add_run(pat, 1'b1, 4); add_run(pat, 1'b0, 2); add_run(pat, 1'b1, 2); add_run(pat, 1'b0, 7);
    presses = 0;
    foreach (pat[i]) begin
      drive(pat[i]);
      e = exp_q.pop_front();
      presses += press_p;
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL reset_lock: sample %0d got %b, expected %b", i, outs(), e);
      end
    end
    n_checks++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL reset_lock_presses: got %0d presses, expected 1", presses);
    end
  endtask

  task automatic test_click();
    logic [6:0] e;
    logic pat[$];
    int click_at;
    add_run(pat, 1'b1, 3); add_run(pat, 1'b0, 8);
    click_at = -1;
    foreach (pat[i]) begin
      drive(pat[i]);
      e = exp_q.pop_front();
      if (click_p) click_at = i;
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL click: sample %0d got %b, expected %b", i, outs(), e);
      end
    end
    n_checks++;
    if (click_at != 7) begin
      n_fail++;
      $display("FAIL click_position: click at sample %0d, expected 7", click_at);
    end
  endtask

  task automatic test_long();
    logic [6:0] e;
    logic pat[$];
    int long_at, clicks;
    add_run(pat, 1'b1, L - 1); add_run(pat, 1'b0, D + 1);
    add_run(pat, 1'b1, L + 3); add_run(pat, 1'b0, D + 2);
    long_at = -1; clicks = 0;
    foreach (pat[i]) begin
      drive(pat[i]);
      e = exp_q.pop_front();
      if (long_p) long_at = i;
      clicks += click_p;
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL long: sample %0d got %b, expected %b", i, outs(), e);
      end
    end
    n_checks++;
    if (long_at != L - 1 + D + 1 + L - 1 || clicks != 1) begin
      n_fail++;
      $display("FAIL long_summary: long at %0d clicks %0d, expected %0d and 1",
               long_at, clicks, L - 1 + D + 1 + L - 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    logic pat[$];
    int dclicks, clicks;
    add_run(pat, 1'b1, 2); add_run(pat, 1'b0, 4); add_run(pat, 1'b1, 2); add_run(pat, 1'b0, 6);
    add_run(pat, 1'b1, 2); add_run(pat, 1'b0, 5); add_run(pat, 1'b1, 2); add_run(pat, 1'b0, 6);
    add_run(pat, 1'b1, 1); add_run(pat, 1'b0, 1); add_run(pat, 1'b1, L); add_run(pat, 1'b0, 6);
    dclicks = 0; clicks = 0;
    foreach (pat[i]) begin
      drive(pat[i]);
      e = exp_q.pop_front();
      dclicks += dclick_p;
      clicks  += click_p;
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL back_to_back: sample %0d got %b, expected %b", i, outs(), e);
      end
    end
    n_checks++;
    if (dclicks != 1 || clicks != 2) begin
      n_fail++;
      $display("FAIL back_to_back_counts: dclick %0d click %0d, expected 1 and 2", dclicks, clicks);
    end
  endtask

  task automatic test_reset_wait2();
    logic [6:0] e;
    int clicks;
    drive(1'b1); void'(exp_q.pop_front());
    drive(1'b1); void'(exp_q.pop_front());
    drive(1'b0); void'(exp_q.pop_front());
    drive(1'b0); void'(exp_q.pop_front());
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (outs() !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_wait2: got %b, expected 0000000", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    clicks = 0;
    for (int i = 0; i < D + 3; i++) begin
      drive(1'b0);
      e = exp_q.pop_front();
      clicks += click_p;
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL reset_wait2_after: sample %0d got %b, expected %b", i, outs(), e);
      end
    end
    n_checks++;
    if (clicks != 0) begin
      n_fail++;
      $display("FAIL reset_wait2_click: got %0d clicks, expected 0", clicks);
    end
  endtask

  task automatic test_repeat();
    logic [6:0] e;
    int rep_cnt, rep_sum;
    rep_cnt = 0; rep_sum = 0;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1);
      e = exp_q.pop_front();
      if (repeat_p) begin
        rep_cnt++; rep_sum += i;
      end
      n_checks++;
      if (outs() !== e) begin
        n_fail++;
        $display("FAIL repeat: sample %0d got %b, expected %b", i, outs(), e);
      end
    end
    drive(1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (outs() !== e || repeat_p !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_release: got %b, expected %b", outs(), e);
    end
`ifdef BTN_REPEAT_EN
    n_checks++;
    if (rep_cnt != 3 || rep_sum != 11 + 14 + 17) begin
      n_fail++;
      $display("FAIL repeat_ticks: %0d ticks sum %0d, expected 3 ticks at 11,14,17", rep_cnt, rep_sum);
    end
`else
    n_checks++;
    if (rep_cnt != 0) begin
      n_fail++;
      $display("FAIL repeat_disabled: %0d ticks, expected 0", rep_cnt);
    end
`endif
    for (int i = 0; i < D + 1; i++) begin
      drive(1'b0); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    logic lvl;
    int len;
    lvl = 1'b1;
    for (int run = 0; run < 120; run++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(L, L + 3 * R + 2) : $urandom_range(1, D + 1);
      for (int k = 0; k < len; k++) begin
        drive(lvl);
        e = exp_q.pop_front();
        n_checks++;
        if (outs() !== e) begin
          n_fail++;
          $display("FAIL random: run %0d step %0d btn %b got %b, expected %b", run, k, lvl, outs(), e);
        end
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    btn = 1'b0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_click();
    test_long();
    test_back_to_back();
    test_reset_wait2();
    test_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
